// File: rtl/count_capture_pkg.sv
// Shared types for the count capture FIFO: the queued entry layout and its width.
package count_capture_pkg;

  localparam int COUNT_W = 8;
  localparam int ENTRY_W = COUNT_W + 1;

  typedef struct packed {
    logic               wrap;
    logic [COUNT_W-1:0] count;
  } entry_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO with occupancy count and a push-accept flag.
// A push into a full FIFO is accepted when the same edge also pops.
module sync_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop_ready,
  output logic [W-1:0]               out_data,
  output logic                       out_valid,
  output logic [$clog2(DEPTH+1)-1:0] fill,
  output logic                       push_ok
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FW-1:0] fill_q, fill_d;
  logic          pop;

  always_comb begin
    out_valid = (fill_q != '0);
    pop       = out_valid && pop_ready;
    push_ok   = push && ((fill_q != FW'(DEPTH)) || pop);
    out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    fill      = fill_q;
    wr_ptr_d  = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    fill_d    = fill_q;
    case ({push_ok, pop})
      2'b10:   fill_d = fill_q + FW'(1);
      2'b01:   fill_d = fill_q - FW'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Storage is not reset; out_data is masked to zero while empty.
  always_ff @(posedge clock) begin
    if (reset && push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/count_capture_fifo.sv
// Snapshots an up-counter on capture strobes, tagging each snapshot with whether
// the counter wrapped since the last accepted one, and queues it for a consumer.
module count_capture_fifo
  import count_capture_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [WIDTH-1:0]           count_in,
  input  logic                       capture,
  output logic [WIDTH:0]             out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] fill,
  output logic                       overflow
);

  logic [WIDTH-1:0] prev_count_q;
  logic             wrap_pending_q, wrap_pending_d;
  logic             overflow_q, overflow_d;
  logic             wrap_now;
  logic             push_ok;
  logic [WIDTH:0]   push_data;

  always_comb begin
    wrap_now  = enable && (prev_count_q == '1) && (count_in == '0);
    push_data = {wrap_pending_q | wrap_now, count_in};
    // A dropped capture keeps the pending wrap so the next accepted entry carries it.
    wrap_pending_d = wrap_pending_q;
    if (capture && push_ok) wrap_pending_d = 1'b0;
    else if (wrap_now)      wrap_pending_d = 1'b1;
    overflow_d = overflow_q | (capture & ~push_ok);
    overflow   = overflow_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      prev_count_q   <= '0;
      wrap_pending_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      prev_count_q   <= count_in;
      wrap_pending_q <= wrap_pending_d;
      overflow_q     <= overflow_d;
    end
  end

  sync_fifo #(
    .W     (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (capture),
    .push_data (push_data),
    .pop_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .fill      (fill),
    .push_ok   (push_ok)
  );

endmodule

// File: tb/tb_count_capture_fifo.sv
// Directed bench: stimulus queues hand-computed entries, a monitor pops and
// compares on every accepted handshake; state checks are done inline.
module tb_count_capture_fifo;
  import count_capture_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] count_in;
  logic       capture;
  logic [8:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] fill;
  logic       overflow;

  int errors = 0;
  int checks = 0;
  entry_t exp_q[$];

  count_capture_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .count_in  (count_in),
    .capture   (capture),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fill      (fill),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  function automatic entry_t mk(input logic w, input logic [7:0] c);
    entry_t e;
    e.wrap  = w;
    e.count = c;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", {23'd0, out_data}, 32'h1ff);
      end else begin
        chk("pop_data", {23'd0, out_data}, {23'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One cycle with the given count; optional capture with its expected entry queued.
  task automatic cyc(input logic [7:0] c, input logic cap, input logic w, input logic keep);
    count_in = c;
    capture  = cap;
    if (cap && keep) exp_q.push_back(mk(w, c));
    tick();
    capture = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 20 && out_valid; i++) tick();
    chk("drain_empty", {31'd0, out_valid}, 32'd0);
    chk("drain_queue", exp_q.size(), 32'd0);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; count_in = 8'd0; capture = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_data", {23'd0, out_data}, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_valid", {31'd0, out_valid}, 32'd0);
      chk("idle_fill", {29'd0, fill}, 32'd0);
      chk("idle_ovf", {31'd0, overflow}, 32'd0);
    end

    // Captures at 3 and 7, consumer stalled.
    for (int c = 0; c < 10; c++) cyc(8'(c), (c == 3) || (c == 7), 1'b0, 1'b1);
    chk("t2_fill", {29'd0, fill}, 32'd2);
    chk("t2_head", {23'd0, out_data}, {23'd0, mk(1'b0, 8'd3)});
    out_ready = 1'b1;
    tick();
    chk("t2_next", {23'd0, out_data}, {23'd0, mk(1'b0, 8'd7)});
    tick();
    chk("t2_empty", {31'd0, out_valid}, 32'd0);

    // Wrap with enable: tag set on the capture at 4, cleared for 6.
    for (int c = 250; c < 256; c++) cyc(8'(c), 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 7; c++) cyc(8'(c), (c == 4) || (c == 6), (c == 4), 1'b1);
    tick();
    chk("t3_empty", {31'd0, out_valid}, 32'd0);

    // Same count sequence with enable low across the wrap: no tag.
    enable = 1'b0;
    for (int c = 250; c < 256; c++) cyc(8'(c), 1'b0, 1'b0, 1'b0);
    cyc(8'd0, 1'b0, 1'b0, 1'b0);
    enable = 1'b1;
    for (int c = 1; c < 5; c++) cyc(8'(c), (c == 4), 1'b0, 1'b1);
    tick();
    chk("t4_empty", {31'd0, out_valid}, 32'd0);

    // Overflow: five captures into four slots.
    out_ready = 1'b0;
    for (int c = 10; c < 14; c++) cyc(8'(c), 1'b1, 1'b0, 1'b1);
    chk("t5_fill4", {29'd0, fill}, 32'd4);
    chk("t5_no_ovf", {31'd0, overflow}, 32'd0);
    cyc(8'd14, 1'b1, 1'b0, 1'b0);
    chk("t5_fill_full", {29'd0, fill}, 32'd4);
    chk("t5_ovf", {31'd0, overflow}, 32'd1);
    out_ready = 1'b1;
    cyc(8'd15, 1'b1, 1'b0, 1'b1);
    out_ready = 1'b0;
    chk("t5_pushpop_fill", {29'd0, fill}, 32'd4);
    chk("t5_pushpop_ovf", {31'd0, overflow}, 32'd1);
    drain();

    // Reset mid-operation flushes the queue and ignores a coincident capture.
    out_ready = 1'b0;
    for (int c = 20; c < 23; c++) cyc(8'(c), 1'b1, 1'b0, 1'b1);
    chk("t6_fill3", {29'd0, fill}, 32'd3);
    reset = 1'b0;
    cyc(8'd23, 1'b1, 1'b0, 1'b0);
    exp_q.delete();
    reset = 1'b1;
    chk("t6_fill", {29'd0, fill}, 32'd0);
    chk("t6_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_ovf", {31'd0, overflow}, 32'd0);
    tick();
    chk("t6_no_capture", {31'd0, out_valid}, 32'd0);

    // Wrap coincides with a dropped capture: the tag survives to the next accepted entry.
    for (int c = 30; c < 34; c++) cyc(8'(c), 1'b1, 1'b0, 1'b1);
    cyc(8'd255, 1'b0, 1'b0, 1'b0);
    cyc(8'd0, 1'b1, 1'b1, 1'b0);
    chk("t7_ovf", {31'd0, overflow}, 32'd1);
    count_in = 8'd1;
    drain();
    cyc(8'd2, 1'b1, 1'b1, 1'b1);
    cyc(8'd3, 1'b1, 1'b0, 1'b1);
    // Accepted capture on the wrap cycle itself: tagged, pending left clear.
    cyc(8'd255, 1'b0, 1'b0, 1'b0);
    cyc(8'd0, 1'b1, 1'b1, 1'b1);
    cyc(8'd1, 1'b1, 1'b0, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/count_capture_fifo.md
# count_capture_fifo

Downstream consumer of the 8-bit up-counter's `count_out`. On each `capture` strobe it snapshots the current count, tags it with whether the counter wrapped since the previous snapshot, and queues the result. Entries drain through a valid/ready interface to the next stage, such as a logger or bus bridge. Overflow of the queue is flagged, never silent.

## Interface
- `WIDTH`, default 8: count width; must match the counter.
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `clock  in  1`: single clock, rising edge.
- `reset  in  1`: synchronous, active-low. Low at a rising edge resets the block.
- `enable  in  1`: the counter's enable, mirrored here. Gates wrap detection.
- `count_in  in  WIDTH`: the counter's `count_out`.
- `capture  in  1`: one-cycle snapshot request.
- `out_data  out  WIDTH+1`: `{wrap_tag, count}` at the FIFO head.
- `out_valid  out  1`: high when the FIFO is non-empty.
- `out_ready  in  1`: consumer accepts the head when `out_valid && out_ready`.
- `fill  out  $clog2(DEPTH+1)`: current occupancy.
- `overflow  out  1`: sticky; set when a capture is dropped.

## Operation
- Wrap detector:
  - Registers `prev_count`, which is updated every cycle from `count_in`.
  - A wrap is defined as `enable==1 && prev_count=={WIDTH{1}} && count_in==0`.
  - A wrap sets `wrap_pending`.
- Capture: when `capture==1`, the entry written is `{wrap_pending | wrap_now, count_in}`.
  - `wrap_pending` clears on every accepted capture.
  - If wrap and capture coincide, the tag is 1 and pending is left clear.
- Push acceptance: a push is accepted if `fill<DEPTH`, or if `fill==DEPTH` and a pop occurs in the same cycle.
  - Otherwise the entry is dropped and `overflow` is set.
  - A dropped capture does not clear `wrap_pending`; the next accepted entry carries the tag.
- Pop: `out_valid && out_ready` advances the head.
  - `out_ready` while empty has no effect.
- Fill arithmetic: `fill` moves +1 on push only, −1 on pop only, and is unchanged when both or neither occur.
  - Pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`.
- `overflow` clears only on reset.
- Reset values: `out_valid=0`, `out_data=0`, `fill=0`, `overflow=0`, `prev_count=0`, `wrap_pending=0`, both pointers 0.
  - Reset asserted mid-operation discards all queued entries at that edge.
  - `capture` asserted in the same cycle as reset is ignored.
- The counter reset does not reset this block.
  - A counter reset from 255 to 0 with `enable=1` therefore registers as a wrap; this is accepted behaviour.

## Timing
- First-word fall-through: a capture at edge N produces `out_valid=1` with that entry on `out_data` after edge N, i.e. 1-cycle latency.
- `out_data` is driven from storage, not combinationally from `count_in`.
- Pop at edge N presents the next entry after edge N. If that pop empties the FIFO, `out_valid` drops after edge N.
- Push and pop in the same edge when `fill==1`: `out_valid` stays 1, `out_data` shows the new entry, and `fill` stays 1.
- Wrap seen at edge N (`prev_count=255`, `count_in=0`) with capture at edge N+k for any k≥0: that entry's tag is 1.
- `overflow` rises on the edge of the first dropped capture.

## Structure
- Package `count_capture_pkg` holds:
  - the `entry_t` packed struct `{logic wrap; logic [WIDTH-1:0] count;}`, with default width 8;
  - the localparam `ENTRY_W = WIDTH+1`.
- Sub-module `sync_fifo` (parameters `W`, `DEPTH`) owns the storage, pointers, `fill`, and the push/pop rules.
- The top level holds the wrap detector, tag logic and overflow flag.

## Test plan
- Reset, then hold `reset` high and `capture` low for 20 cycles → `out_valid=0`, `fill=0`, `overflow=0` throughout.
- `enable=1`, count 0..9, capture at count=3, 7, `out_ready=0` → `fill=2`, head `{0,8'd3}`. Then `out_ready=1` → `{0,8'd7}` next cycle, then `out_valid=0`.
- Count runs 250→255→0→4, capture at 4 → entry `{1,8'd4}`. A second capture at 6 → `{0,8'd6}`.
- Same wrap but `enable=0` across 255→0 → capture at 4 gives `{0,8'd4}`.
- `out_ready=0`, 5 captures at counts 10..14 → `fill=4` and `overflow=1` after the 5th capture. Drain order is 10, 11, 12, 13. With the FIFO full, a capture together with `out_ready=1` → the entry is accepted, `fill` stays 4, and `overflow` is unchanged.
- Queue 3 entries, then assert `reset=0` for one cycle → `fill=0`, `out_valid=0`, `overflow=0` on the next cycle. A capture during reset is not queued.
